multi_valid_move_detector: RTL and testbench
============================================

# multi_valid_move_detector

Parametrised, multi-channel successor to the single-sprite valid-move detector. Arbitrates position queries from up to N_CH sprites (player plus ghosts) round-robin, maps each display coordinate to a maze tile, reads the four neighbour tiles from a shared synchronous maze memory, and returns a per-channel 4-bit valid-move mask plus tile-centre alignment and off-map flags. Sits between the sprite movement controllers and the maze ROM in the game backend.

## Interface
- N_CH, 4: number of requesting channels (1..8)
- MAP_W, 16: maze width in tiles
- MAP_H, 16: maze height in tiles
- TILE_LOG2, 4: log2 of tile edge in pixels
- ORIGIN_X, 336: display x of tile (0,0) left edge
- ORIGIN_Y, 27: display y of tile (0,0) top edge
- CENTER, 7: in-tile pixel offset that counts as tile centre
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_CH  per-channel query request, held until ready
- pos_x  in  N_CH*11  per-channel display x, channel i at [11i+10:11i]
- pos_y  in  N_CH*10  per-channel display y, channel i at [10i+9:10i]
- ready  out  N_CH  one-hot; high for the single cycle channel i is accepted
- resp_valid  out  N_CH  one-hot single-cycle response strobe
- valid_moves  out  N_CH*4  per-channel {up,down,left,right}, 1 = move allowed; held until that channel's next response
- aligned  out  N_CH  position sits exactly on tile centre in both axes
- off_map  out  N_CH  position outside the maze area
- mem_en  out  1  maze memory read enable
- mem_addr  out  clog2(MAP_W*MAP_H)  row*MAP_W + col
- mem_wall  in  1  read data, 1 = wall, valid the cycle after mem_en

## Operation
- FSM states: IDLE, CALC, RD_UP, RD_DN, RD_LT, RD_RT, WAIT, RESP.
- IDLE: if any req, grant lowest-index requester at or after rr_ptr (circularly); pulse ready[i], latch pos_x/pos_y of i; rr_ptr <= i+1 mod N_CH; -> CALC.
- CALC: dx = pos_x-ORIGIN_X, dy = pos_y-ORIGIN_Y (12-bit signed); col = dx>>TILE_LOG2, row = dy>>TILE_LOG2; off_map if dx<0, dy<0, col>=MAP_W or row>=MAP_H; aligned = (dx[TILE_LOG2-1:0]==CENTER)&&(dy[TILE_LOG2-1:0]==CENTER)&&!off_map.
- RD_UP/DN/LT/RT: one cycle each, issue address of (row-1,col),(row+1,col),(row,col-1),(row,col+1). Neighbour outside grid or off_map: mem_en=0, direction forced invalid. Otherwise mem_en=1; bit = !mem_wall captured next cycle.
- WAIT: capture last read data. RESP: write mask/flags to channel i, pulse resp_valid[i]; -> IDLE.
- off_map response: valid_moves=0, aligned=0, off_map=1.
- Requests arriving while busy wait; no request is dropped. Deasserting req before ready is allowed (withdrawn).

## Timing
- Acceptance edge E0 (ready high in cycle before E0); resp_valid high in cycle after E7; fixed latency 7, identical for off_map/edge cases.
- Throughput: one query per 8 cycles; next grant in the RESP->IDLE cycle after.
- mem_addr stable whenever mem_en=1; mem_addr=0 when mem_en=0.
- Reset (any time, mid-query included): FSM IDLE, rr_ptr=0, ready=0, resp_valid=0, mem_en=0, mem_addr=0, valid_moves=0, aligned=0, off_map=0; in-flight query discarded.

## Structure
- Shared package maze_pkg: direction bit indices (UP=3,DN=2,LT=1,RT=0), default MAP_W/MAP_H/TILE_LOG2/ORIGIN/CENTER constants, FSM state encoding.
- One sub-module: rr_arbiter (N_CH-wide round-robin, one-hot grant, pointer update on grant).
- Coordinate-to-tile mapping is a function in maze_pkg, shared with the display index mapper.

## Test plan
- Single channel, maze with wall only right of (7,7): pos (455,146) -> tile (7,7), valid_moves=4'b1110, aligned=1, off_map=0, resp_valid 7 cycles after accept.
- Open maze: pos (487,114) -> tile (9,5), valid_moves=4'b1111, aligned=1; pos (490,114) -> same mask, aligned=0.
- Corner (0,0) open maze: pos (343,34) -> valid_moves=4'b0101, mem_en only on DN and RT cycles.
- Off-map: pos (300,20) -> valid_moves=0, off_map=1, no mem_en, latency still 7.
- N_CH=4, all req held from reset: grants in order 0,1,2,3,0 with 8-cycle spacing, each resp_valid on correct channel.
- rst_n low at cycle 3 of a query: all outputs zero immediately, no resp_valid; after release, held req re-granted from channel 0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze constants, FSM state type and the display-to-tile mapping
// used by the move detector and the display index mapper.
package maze_pkg;

  localparam int unsigned DIR_UP = 3;
  localparam int unsigned DIR_DN = 2;
  localparam int unsigned DIR_LT = 1;
  localparam int unsigned DIR_RT = 0;

  localparam int unsigned DEF_MAP_W     = 16;
  localparam int unsigned DEF_MAP_H     = 16;
  localparam int unsigned DEF_TILE_LOG2 = 4;
  localparam int unsigned DEF_ORIGIN_X  = 336;
  localparam int unsigned DEF_ORIGIN_Y  = 27;
  localparam int unsigned DEF_CENTER    = 7;

  typedef enum logic [2:0] {
    IDLE, CALC, RD_UP, RD_DN, RD_LT, RD_RT, WAIT, RESP
  } state_t;

  typedef struct packed {
    logic        off_map;
    logic        aligned;
    logic [11:0] row;
    logic [11:0] col;
  } tile_t;

  // Negative offsets show up as bit 11 of the 12-bit difference.
  function automatic tile_t map_tile(input logic [10:0] x, input logic [9:0] y,
                                     input int unsigned ox, input int unsigned oy,
                                     input int unsigned tl2, input int unsigned w,
                                     input int unsigned h, input int unsigned ctr);
    tile_t       t;
    logic [11:0] dx;
    logic [11:0] dy;
    logic [11:0] msk;
    dx        = {1'b0, x} - 12'(ox);
    dy        = {2'b00, y} - 12'(oy);
    t.col     = dx >> tl2;
    t.row     = dy >> tl2;
    t.off_map = dx[11] | dy[11] | (32'(t.col) >= w) | (32'(t.row) >= h);
    msk       = (12'd1 << tl2) - 12'd1;
    t.aligned = ((dx & msk) == 12'(ctr)) && ((dy & msk) == 12'(ctr)) && !t.off_map;
    return t;
  endfunction

endpackage

// File: rtl/multi_valid_move_detector_if.sv
// Query/response bus between sprite controllers, the detector and the maze memory.
interface multi_valid_move_detector_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned ADDR_W = 8
);
    logic [N_CH-1:0]    req;
    logic [N_CH*11-1:0] pos_x;
    logic [N_CH*10-1:0] pos_y;
    logic [N_CH-1:0]    ready;
    logic [N_CH-1:0]    resp_valid;
    logic [N_CH*4-1:0]  valid_moves;
    logic [N_CH-1:0]    aligned;
    logic [N_CH-1:0]    off_map;
    logic               mem_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_wall;

    modport slave (
        input  req, pos_x, pos_y, mem_wall,
        output ready, resp_valid, valid_moves, aligned, off_map, mem_en, mem_addr
    );

    modport master (
        output req, pos_x, pos_y, mem_wall,
        input  ready, resp_valid, valid_moves, aligned, off_map, mem_en, mem_addr
    );
endinterface

// File: rtl/multi_valid_move_detector_rr_arbiter.sv
// N-wide round-robin arbiter: one-hot grant starting at the pointer, pointer
// advances past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    logic [IW-1:0] ptr;
    logic          found;
    int unsigned   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        gnt_any = found & en;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ptr <= '0;
        else if (gnt_any) ptr <= IW'((32'(gnt_idx) + 1) % N);
    end
endmodule

// File: rtl/multi_valid_move_detector.sv
// Multi-channel valid-move detector: arbitrates sprite queries and probes the
// four neighbour tiles in the shared maze memory, fixed 7-cycle latency.
module multi_valid_move_detector
  import maze_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned MAP_W     = DEF_MAP_W,
    parameter int unsigned MAP_H     = DEF_MAP_H,
    parameter int unsigned TILE_LOG2 = DEF_TILE_LOG2,
    parameter int unsigned ORIGIN_X  = DEF_ORIGIN_X,
    parameter int unsigned ORIGIN_Y  = DEF_ORIGIN_Y,
    parameter int unsigned CENTER    = DEF_CENTER
) (
    input logic clk,
    input logic rst_n,
    multi_valid_move_detector_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(MAP_W * MAP_H);
    localparam int unsigned IW     = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t              state;
    logic [10:0]         px;
    logic [9:0]          py;
    logic [IW-1:0]       ch;
    logic [3:0]          mask;
    logic                en_q;
    logic                mem_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [N_CH-1:0]     resp_valid_q;
    logic [N_CH*4-1:0]   valid_moves_q;
    logic [N_CH-1:0]     aligned_q;
    logic [N_CH-1:0]     off_map_q;
    logic [N_CH-1:0]     gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;
    logic                arb_en;
    tile_t               tile;
    logic                rd_ok;
    logic [ADDR_W-1:0]   rd_addr;
    int unsigned         nr;
    int unsigned         nc;

    // Gating with rst_n keeps ready low while reset is held.
    assign arb_en = (state == IDLE) && rst_n;

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb tile = map_tile(px, py, ORIGIN_X, ORIGIN_Y, TILE_LOG2, MAP_W, MAP_H, CENTER);

    // Address for the read issued in the next state, registered on the transition.
    always_comb begin
        rd_ok = 1'b0;
        nr    = 32'(tile.row);
        nc    = 32'(tile.col);
        case (state)
            CALC:  begin rd_ok = (tile.row != '0);         nr = 32'(tile.row) - 1; end
            RD_UP: begin rd_ok = (32'(tile.row) + 1 < MAP_H); nr = 32'(tile.row) + 1; end
            RD_DN: begin rd_ok = (tile.col != '0);         nc = 32'(tile.col) - 1; end
            RD_LT: begin rd_ok = (32'(tile.col) + 1 < MAP_W); nc = 32'(tile.col) + 1; end
            default: rd_ok = 1'b0;
        endcase
        rd_ok   = rd_ok & ~tile.off_map;
        rd_addr = rd_ok ? ADDR_W'(nr * MAP_W + nc) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            px            <= '0;
            py            <= '0;
            ch            <= '0;
            mask          <= '0;
            en_q          <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            resp_valid_q  <= '0;
            valid_moves_q <= '0;
            aligned_q     <= '0;
            off_map_q     <= '0;
        end else begin
            resp_valid_q <= '0;
            mem_en_q     <= rd_ok;
            mem_addr_q   <= rd_addr;
            en_q         <= mem_en_q;
            case (state)
                IDLE: if (gnt_any) begin
                    ch    <= gnt_idx;
                    px    <= bus.pos_x[11*gnt_idx +: 11];
                    py    <= bus.pos_y[10*gnt_idx +: 10];
                    state <= CALC;
                end
                CALC:  begin mask <= '0; state <= RD_UP; end
                RD_UP: state <= RD_DN;
                // Each read's data lands one state later; en_q says whether it was issued.
                RD_DN: begin mask[DIR_UP] <= en_q & ~bus.mem_wall; state <= RD_LT; end
                RD_LT: begin mask[DIR_DN] <= en_q & ~bus.mem_wall; state <= RD_RT; end
                RD_RT: begin mask[DIR_LT] <= en_q & ~bus.mem_wall; state <= WAIT;  end
                WAIT:  begin mask[DIR_RT] <= en_q & ~bus.mem_wall; state <= RESP;  end
                RESP: begin
                    valid_moves_q[4*ch +: 4] <= mask;
                    aligned_q[ch]            <= tile.aligned;
                    off_map_q[ch]            <= tile.off_map;
                    resp_valid_q[ch]         <= 1'b1;
                    state                    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready       = gnt;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.valid_moves = valid_moves_q;
    assign bus.aligned     = aligned_q;
    assign bus.off_map     = off_map_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_multi_valid_move_detector.sv
// Directed bench for multi_valid_move_detector with a synchronous maze memory model.
module tb_multi_valid_move_detector;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic walls [0:255];

    multi_valid_move_detector_if #(.N_CH(4), .ADDR_W(8)) bus ();

    multi_valid_move_detector #(.N_CH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_en) bus.mem_wall <= walls[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.ready), 0);
        check({tag, "_rv"},    32'(bus.resp_valid), 0);
        check({tag, "_men"},   32'(bus.mem_en), 0);
        check({tag, "_madr"},  32'(bus.mem_addr), 0);
        check({tag, "_vm"},    32'(bus.valid_moves), 0);
        check({tag, "_al"},    32'(bus.aligned), 0);
        check({tag, "_off"},   32'(bus.off_map), 0);
    endtask

    // Single query on channel ch; en is the expected {UP,DN,LT,RT} mem_en pattern.
    task automatic run_query(input int ch, input logic [10:0] x, input logic [9:0] y,
                             input logic [3:0] em, input logic ea, input logic eo,
                             input logic [3:0] een, input string tag,
                             output logic [31:0] addrs);
        int         n;
        logic [3:0] en_seen;
        logic [3:0] rv_early;
        bus.pos_x[11*ch +: 11] = x;
        bus.pos_y[10*ch +: 10] = y;
        bus.req[ch] = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.ready == 0 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_ready"}, 32'(bus.ready), 32'(1) << ch);
        en_seen  = '0;
        rv_early = '0;
        addrs    = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.req[ch] = 1'b0;
            if (k >= 2 && k <= 5) begin
                en_seen[5-k]           = bus.mem_en;
                addrs[8*(5-k) +: 8]    = bus.mem_addr;
            end
            if (k < 8) rv_early |= bus.resp_valid;
        end
        check({tag, "_early_rv"}, 32'(rv_early), 0);
        check({tag, "_rv"},       32'(bus.resp_valid), 32'(1) << ch);
        check({tag, "_vm"},       32'(bus.valid_moves[4*ch +: 4]), 32'(em));
        check({tag, "_al"},       32'(bus.aligned[ch]), 32'(ea));
        check({tag, "_off"},      32'(bus.off_map[ch]), 32'(eo));
        check({tag, "_men"},      32'(en_seen), 32'(een));
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        int          last;

        rst_n = 1'b0;
        bus.req = '0;
        bus.pos_x = '0;
        bus.pos_y = '0;
        for (int i = 0; i < 256; i++) walls[i] = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Wall only right of (7,7): neighbour addresses 103,135,118,120
        walls[120] = 1'b1;
        run_query(0, 11'd455, 10'd146, 4'b1110, 1'b1, 1'b0, 4'b1111, "t77", a);
        check("t77_addr", a, {8'd103, 8'd135, 8'd118, 8'd120});
        walls[120] = 1'b0;

        run_query(1, 11'd487, 10'd114, 4'b1111, 1'b1, 1'b0, 4'b1111, "open", a);
        check("open_addr", a, {8'd73, 8'd105, 8'd88, 8'd90});
        run_query(2, 11'd490, 10'd114, 4'b1111, 1'b0, 1'b0, 4'b1111, "unal", a);
        run_query(3, 11'd343, 10'd34,  4'b0101, 1'b1, 1'b0, 4'b0101, "c00", a);
        check("c00_addr", a, {8'd0, 8'd16, 8'd0, 8'd1});
        run_query(0, 11'd300, 10'd20,  4'b0000, 1'b0, 1'b1, 4'b0000, "offlo", a);
        run_query(1, 11'd583, 10'd274, 4'b1010, 1'b1, 1'b0, 4'b1010, "c1515", a);
        run_query(2, 11'd592, 10'd146, 4'b0000, 1'b0, 1'b1, 4'b0000, "offhi", a);

        // All four channels requesting from reset: order 0,1,2,3,0 at 8-cycle spacing
        bus.pos_x = {11'd583, 11'd300, 11'd343, 11'd487};
        bus.pos_y = {10'd274, 10'd20,  10'd34,  10'd114};
        rst_n = 1'b0;
        bus.req = 4'hF;
        repeat (2) @(negedge clk);
        check("mc_rst_ready", 32'(bus.ready), 0);
        rst_n = 1'b1;
        #1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (bus.ready == 0 && n < 20) begin @(negedge clk); n++; end
            check("mc_gnt", 32'(bus.ready), 32'(1) << (g % 4));
            if (g > 0) begin
                check("mc_gap",  32'(cyc - last), 8);
                check("mc_resp", 32'(bus.resp_valid), 32'(1) << ((g - 1) % 4));
            end
            last = cyc;
            if (g < 4) @(negedge clk);
        end
        check("mc_vm",  32'(bus.valid_moves), 32'h0000_A05F);
        check("mc_al",  32'(bus.aligned), 32'b1011);
        check("mc_off", 32'(bus.off_map), 32'b0100);

        // Reset during cycle 3 of channel 0's query; held requests restart at channel 0
        bus.req = 4'b0011;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        check("midrst_rv_hold", 32'(bus.resp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_regrant", 32'(bus.ready), 32'b0001);
        @(negedge clk);
        bus.req = 4'b0000;
        repeat (7) @(negedge clk);
        check("midrst_rv", 32'(bus.resp_valid), 32'b0001);
        check("midrst_vm", 32'(bus.valid_moves), 32'h0000_000F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
